// File: rtl/divider_signed_iter.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle, with optional
// two's-complement operands, divide-by-zero and signed-overflow flagging.
module divider_signed_iter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strt,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             not_valid,
  output logic             idle,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_SIGN} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend magnitude, becomes quotient magnitude
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] quo_out_q, quo_out_d;
  logic [WIDTH-1:0] rem_out_q, rem_out_d;
  logic             nv_q, nv_d;
  logic             idle_q, idle_d;
  logic             done_q, done_d;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      ovf_q     <= 1'b0;
      quo_out_q <= '0;
      rem_out_q <= '0;
      nv_q      <= 1'b0;
      idle_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      ovf_q     <= ovf_d;
      quo_out_q <= quo_out_d;
      rem_out_q <= rem_out_d;
      nv_q      <= nv_d;
      idle_q    <= idle_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    ovf_d     = ovf_q;
    quo_out_d = quo_out_q;
    rem_out_d = rem_out_q;
    nv_d      = nv_q;
    done_d    = 1'b0;
    // Partial remainder widened by one bit so the trial subtraction's borrow is visible.
    shifted   = {rem_q, dvd_q[WIDTH-1]};
    trial     = shifted - {1'b0, dvs_q};

    unique case (state_q)
      S_IDLE: begin
        if (strt) begin
          nv_d = 1'b0;
          if (divisor == '0) begin
            quo_out_d = '1;
            rem_out_d = dividend;
            nv_d      = 1'b1;
            done_d    = 1'b1;
          end else begin
            dvd_d   = (signed_mode && dividend[WIDTH-1]) ? WIDTH'(-dividend) : dividend;
            dvs_d   = (signed_mode && divisor[WIDTH-1])  ? WIDTH'(-divisor)  : divisor;
            rem_d   = '0;
            cnt_d   = CW'(WIDTH - 1);
            qneg_d  = signed_mode && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rneg_d  = signed_mode && dividend[WIDTH-1];
            ovf_d   = signed_mode && (dividend == MOST_NEG) && (divisor == '1);
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = S_SIGN;
        end
      end
      S_SIGN: begin
        quo_out_d = qneg_q ? WIDTH'(-dvd_q) : dvd_q;
        rem_out_d = rneg_q ? WIDTH'(-rem_q) : rem_q;
        nv_d      = ovf_q;
        done_d    = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    idle_d = (state_d == S_IDLE);
  end

  assign quotient  = quo_out_q;
  assign remainder = rem_out_q;
  assign not_valid = nv_q;
  assign idle      = idle_q;
  assign done      = done_q;

endmodule
